// File: rtl/bsg_tx_ctrl_if.sv
// Register bus and modulator byte stream for bsg_tx_ctrl.
// The slave modport is the controller's view; the master modport is the host/modulator side.
interface bsg_tx_ctrl_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  WRITE_ENABLE;
    logic [DATA_WIDTH-1:0] addr_in;
    logic [DATA_WIDTH-1:0] data_in;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  mod_enable;
    logic                  mod_valid;
    logic [DATA_WIDTH-1:0] mod_data;
    logic                  mod_ready;

    modport slave (
        input  WRITE_ENABLE, addr_in, data_in, mod_ready,
        output rd_data, mod_enable, mod_valid, mod_data
    );

    modport master (
        output WRITE_ENABLE, addr_in, data_in, mod_ready,
        input  rd_data, mod_enable, mod_valid, mod_data
    );
endinterface

// File: rtl/bsg_tx_ctrl.sv
// TX controller: register-mapped byte FIFO feeding a valid/ready modulator stream.
// STATUS = {count, OVF, busy, full, empty}; CTRL = {FLUSH, EN}.
module bsg_tx_ctrl #(
    parameter int                    DATA_WIDTH  = 8,
    parameter int                    FIFO_DEPTH  = 4,
    parameter logic [DATA_WIDTH-1:0] CTRL_ADDR   = 'h00,
    parameter logic [DATA_WIDTH-1:0] DATA_ADDR   = 'h01,
    parameter logic [DATA_WIDTH-1:0] STATUS_ADDR = 'h02
) (
    input logic          G_CLK_TX,
    input logic          rst,
    bsg_tx_ctrl_if.slave bus
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic {IDLE, PRESENT} state_t;

    state_t                state_q, state_d;
    logic                  en_q, ovf_q;
    logic [PW-1:0]         wr_ptr, rd_ptr;
    logic [CW-1:0]         count_q;
    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] mod_data_q, rd_data_q, rd_mux;
    logic [7:0]            status;
    logic                  wr_ctrl, wr_data, wr_stat;
    logic                  flush, empty, full, pop, push, drop;

    assign wr_ctrl = bus.WRITE_ENABLE && (bus.addr_in == CTRL_ADDR);
    assign wr_data = bus.WRITE_ENABLE && (bus.addr_in == DATA_ADDR);
    assign wr_stat = bus.WRITE_ENABLE && (bus.addr_in == STATUS_ADDR);
    assign flush   = wr_ctrl && bus.data_in[1];
    assign empty   = (count_q == '0);
    assign full    = (count_q == CW'(FIFO_DEPTH));
    // A full FIFO still accepts a byte when the head leaves in the same cycle.
    assign push    = wr_data && (!full || pop);
    assign drop    = wr_data && full && !pop;

    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (en_q && !empty) begin
                    pop     = 1'b1;
                    state_d = PRESENT;
                end
            end
            PRESENT: begin
                if (bus.mod_ready) begin
                    if (en_q && !empty) pop = 1'b1;
                    else state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (flush) begin
            pop     = 1'b0;
            state_d = IDLE;
        end
    end

    assign status = {4'(count_q), ovf_q, (state_q == PRESENT), full, empty};

    always_comb begin
        rd_mux = '0;
        unique case (1'b1)
            (bus.addr_in == CTRL_ADDR):   rd_mux = DATA_WIDTH'(en_q);
            (bus.addr_in == STATUS_ADDR): rd_mux = DATA_WIDTH'(status);
            default:                      rd_mux = '0;
        endcase
    end

    always_ff @(posedge G_CLK_TX or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            en_q       <= 1'b0;
            ovf_q      <= 1'b0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count_q    <= '0;
            mod_data_q <= '0;
            rd_data_q  <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
        end else begin
            state_q <= state_d;
            if (wr_ctrl) en_q <= bus.data_in[0];
            if (drop) ovf_q <= 1'b1;
            else if (wr_stat && bus.data_in[3]) ovf_q <= 1'b0;
            if (!bus.WRITE_ENABLE) rd_data_q <= rd_mux;
            if (push) mem[wr_ptr] <= bus.data_in;
            if (flush) begin
                wr_ptr     <= '0;
                rd_ptr     <= '0;
                count_q    <= '0;
                mod_data_q <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + 1'b1;
                if (pop) begin
                    rd_ptr     <= rd_ptr + 1'b1;
                    mod_data_q <= mem[rd_ptr];
                end
                if (push && !pop) count_q <= count_q + 1'b1;
                else if (pop && !push) count_q <= count_q - 1'b1;
            end
        end
    end

    assign bus.mod_valid  = (state_q == PRESENT);
    assign bus.mod_enable = en_q;
    assign bus.mod_data   = mod_data_q;
    assign bus.rd_data    = rd_data_q;
endmodule

// File: tb/tb_bsg_tx_ctrl.sv
// Scoreboard bench for bsg_tx_ctrl: directed register writes, monitor checks
// every modulator transfer against a queue of expected bytes.
module tb_bsg_tx_ctrl;
    localparam logic [7:0] CTRL = 8'h00;
    localparam logic [7:0] DATA = 8'h01;
    localparam logic [7:0] STAT = 8'h02;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_tests = 0;
    int   n_fail = 0;
    logic [7:0] exp_q[$];
    logic [7:0] v;

    always #5 clk = ~clk;

    bsg_tx_ctrl_if #(.DATA_WIDTH(8)) bus ();

    bsg_tx_ctrl #(.DATA_WIDTH(8), .FIFO_DEPTH(4)) dut (
        .G_CLK_TX(clk),
        .rst     (rst_n),
        .bus     (bus)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wr(input logic [7:0] a, input logic [7:0] d);
        bus.WRITE_ENABLE = 1'b1;
        bus.addr_in = a;
        bus.data_in = d;
        @(posedge clk);
        #1;
        bus.WRITE_ENABLE = 1'b0;
    endtask

    task automatic rd(input logic [7:0] a, output logic [7:0] val);
        bus.addr_in = a;
        @(posedge clk);
        #1;
        val = bus.rd_data;
    endtask

    task automatic cyc(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Monitor: a transfer will happen at the next rising edge.
    always @(negedge clk) begin
        if (rst_n && bus.mod_valid && bus.mod_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_byte", {24'h0, bus.mod_data}, 32'hFFFF_FFFF);
            end else begin
                check("xfer_data", {24'h0, bus.mod_data}, {24'h0, exp_q.pop_front()});
            end
        end
    end

    initial begin
        bus.WRITE_ENABLE = 1'b0;
        bus.addr_in = '0;
        bus.data_in = '0;
        bus.mod_ready = 1'b0;
        #3;
        check("rst_valid", {31'h0, bus.mod_valid}, 0);
        check("rst_data", {24'h0, bus.mod_data}, 0);
        check("rst_en", {31'h0, bus.mod_enable}, 0);
        check("rst_rd", {24'h0, bus.rd_data}, 0);
        #9;
        rst_n = 1'b1;
        cyc(1);
        rd(STAT, v);
        check("rst_status", {24'h0, v}, 32'h01);

        // Basic transfer and latency
        bus.mod_ready = 1'b1;
        wr(CTRL, 8'h01);
        check("en_set", {31'h0, bus.mod_enable}, 1);
        exp_q.push_back(8'hA5);
        wr(DATA, 8'hA5);
        check("basic_pre", {31'h0, bus.mod_valid}, 0);
        cyc(1);
        check("basic_valid", {31'h0, bus.mod_valid}, 1);
        check("basic_data", {24'h0, bus.mod_data}, 32'hA5);
        cyc(1);
        check("basic_idle", {31'h0, bus.mod_valid}, 0);

        // Backpressure then back-to-back drain
        bus.mod_ready = 1'b0;
        exp_q.push_back(8'h11);
        exp_q.push_back(8'h22);
        exp_q.push_back(8'h33);
        wr(DATA, 8'h11);
        wr(DATA, 8'h22);
        wr(DATA, 8'h33);
        for (int i = 0; i < 5; i++) begin
            check("bp_hold_valid", {31'h0, bus.mod_valid}, 1);
            check("bp_hold_data", {24'h0, bus.mod_data}, 32'h11);
            cyc(1);
        end
        bus.mod_ready = 1'b1;
        check("b2b_0", {23'h0, bus.mod_valid, bus.mod_data}, 32'h111);
        cyc(1);
        check("b2b_1", {23'h0, bus.mod_valid, bus.mod_data}, 32'h122);
        cyc(1);
        check("b2b_2", {23'h0, bus.mod_valid, bus.mod_data}, 32'h133);
        cyc(1);
        check("b2b_idle", {31'h0, bus.mod_valid}, 0);

        // Overflow with EN=0
        wr(CTRL, 8'h00);
        for (int i = 1; i <= 5; i++) wr(DATA, 8'(i));
        rd(STAT, v);
        check("ovf_status", {24'h0, v}, 32'h4A);
        wr(STAT, 8'h08);
        rd(STAT, v);
        check("ovf_clear", {24'h0, v}, 32'h42);
        for (int i = 1; i <= 4; i++) exp_q.push_back(8'(i));
        wr(CTRL, 8'h01);
        cyc(8);
        rd(STAT, v);
        check("ovf_drained", {24'h0, v}, 32'h01);
        rd(8'h07, v);
        check("unmapped_rd", {24'h0, v}, 32'h00);
        rd(CTRL, v);
        check("ctrl_rd", {24'h0, v}, 32'h01);

        // Full FIFO with simultaneous push and pop
        bus.mod_ready = 1'b0;
        exp_q.push_back(8'hA0);
        for (int i = 1; i <= 4; i++) exp_q.push_back(8'hA0 + 8'(i));
        exp_q.push_back(8'h77);
        for (int i = 0; i <= 4; i++) wr(DATA, 8'hA0 + 8'(i));
        rd(STAT, v);
        check("full_status", {24'h0, v}, 32'h46);
        bus.mod_ready = 1'b1;
        wr(DATA, 8'h77);
        rd(STAT, v);
        check("full_pushpop", {24'h0, v}, 32'h46);
        cyc(10);
        rd(STAT, v);
        check("full_drained", {24'h0, v}, 32'h01);

        // Flush while presenting
        bus.mod_ready = 1'b0;
        for (int i = 1; i <= 4; i++) wr(DATA, 8'h30 + 8'(i));
        check("fl_pre_valid", {31'h0, bus.mod_valid}, 1);
        wr(CTRL, 8'h03);
        check("fl_valid", {31'h0, bus.mod_valid}, 0);
        check("fl_en", {31'h0, bus.mod_enable}, 1);
        rd(STAT, v);
        check("fl_status", {24'h0, v}, 32'h01);
        rd(CTRL, v);
        check("fl_ctrl_rd", {24'h0, v}, 32'h01);

        // Asynchronous reset mid-operation
        for (int i = 1; i <= 3; i++) wr(DATA, 8'h40 + 8'(i));
        rd(STAT, v);
        check("pre_rst_status", {24'h0, v}, 32'h24);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_valid", {31'h0, bus.mod_valid}, 0);
        check("arst_data", {24'h0, bus.mod_data}, 0);
        check("arst_en", {31'h0, bus.mod_enable}, 0);
        check("arst_rd", {24'h0, bus.rd_data}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        rd(STAT, v);
        check("post_rst_status", {24'h0, v}, 32'h01);

        cyc(2);
        check("sb_empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
